// File: rtl/clk_monitor.sv
// clk_monitor
// Receive-side checker for the divided clock from the frequency divider.
// clk_in is brought into the CCLK domain through a two-flop synchronizer.
// Each synchronized edge produces a rise/fall strobe. Each half-period is
// measured in CCLK cycles and compared with the expected half-period
// E = clk_scale + 1, with an allowed deviation of +/- TOL cycles.
//
// Ports
//   CCLK        system clock, all logic on its rising edge
//   reset       synchronous, active-high
//   clk_in      divided clock under test (asynchronous to CCLK)
//   clk_scale   divider setting, sampled live; E = clk_scale + 1
//   clr_err     clears the sticky err flag
//   rise/fall   one-cycle strobes on synchronized clk_in edges
//   half_period most recent measured half-period, in CCLK cycles
//   valid       one-cycle strobe when half_period updates
//   locked      set after LOCK_COUNT consecutive good measurements
//   err         sticky: out-of-tolerance measurement or stall
//   stall       one-cycle strobe when an edge is overdue
module clk_monitor #(
  parameter int TOL        = 2,
  parameter int LOCK_COUNT = 4
) (
  input  logic        CCLK,
  input  logic        reset,
  input  logic        clk_in,
  input  logic [31:0] clk_scale,
  input  logic        clr_err,
  output logic        rise,
  output logic        fall,
  output logic [31:0] half_period,
  output logic        valid,
  output logic        locked,
  output logic        err,
  output logic        stall
);

  localparam int GW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {SEEK, MEASURE, LOCKED} state_t;

  state_t        state;
  logic          s1, s2, s3;
  logic [31:0]   cnt;
  logic [GW-1:0] good_cnt;
  logic [GW-1:0] good_nxt;
  logic          e;
  logic [32:0]   exp_hp;
  logic [32:0]   meas;
  logic          good;
  logic          overdue;
  logic          err_set;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Lower bound clamps at zero so a small E with TOL >= E cannot wrap.
  function automatic logic in_tol(input logic [32:0] m, input logic [32:0] expv);
    logic [32:0] lo;
    logic [32:0] hi;
    hi = expv + 33'(TOL);
    lo = (expv > 33'(TOL)) ? expv - 33'(TOL) : 33'd0;
    return (m >= lo) && (m <= hi);
  endfunction

  // 33-bit arithmetic keeps clk_scale = 0xFFFFFFFF from wrapping.
  assign e        = s2 ^ s3;
  assign exp_hp   = {1'b0, clk_scale} + 33'd1;
  assign meas     = {1'b0, cnt} + 33'd1;
  assign good     = in_tol(meas, exp_hp);
  assign good_nxt = good_cnt + GW'(1);
  // Without an edge in this cycle, any later edge would measure more than
  // E + TOL, so the stall is declared now and shows up next cycle.
  assign overdue  = (meas >= exp_hp + 33'(TOL));
  assign err_set  = (state != SEEK) && (e ? !good : overdue);

  always_ff @(posedge CCLK) begin
    if (reset) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      cnt         <= '0;
      good_cnt    <= '0;
      state       <= SEEK;
      rise        <= 1'b0;
      fall        <= 1'b0;
      half_period <= '0;
      valid       <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
      stall       <= 1'b0;
    end else begin
      // Synchronizer stage; s3 is the edge-detect reference
      s1 <= clk_in;
      s2 <= s1;
      s3 <= s2;

      // Edge / measurement stage
      rise  <= e & s2;
      fall  <= e & ~s2;
      cnt   <= e ? 32'd0 : sat_inc(cnt);
      valid <= 1'b0;
      stall <= 1'b0;
      // A same-cycle error set wins over clr_err.
      err   <= err_set | (err & ~clr_err);

      case (state)
        SEEK: begin
          if (e) state <= MEASURE;
        end
        MEASURE, LOCKED: begin
          if (e) begin
            half_period <= meas[31:0];
            valid       <= 1'b1;
            if (good) begin
              if (state == MEASURE) begin
                good_cnt <= good_nxt;
                if (good_nxt == GW'(LOCK_COUNT)) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end
            end else begin
              good_cnt <= '0;
              locked   <= 1'b0;
              state    <= MEASURE;
            end
          end else if (overdue) begin
            state    <= SEEK;
            stall    <= 1'b1;
            locked   <= 1'b0;
            good_cnt <= '0;
          end
        end
        default: state <= SEEK;
      endcase
    end
  end

endmodule
